// File: rtl/prbs_gen_param.sv
// Parametrised Galois-LFSR PRBS generator with a valid/ready word output.
// Emits OUT_BITS sequence bits per word, MSB-first; recovers from zero seeds.
module prbs_gen_param #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] POLY        = 8'h1D,
    parameter logic [WIDTH-1:0] RESET_VALUE = 8'hB4,
    parameter int               OUT_BITS    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                seed_load,
    input  logic [WIDTH-1:0]    seed_in,
    output logic [OUT_BITS-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    lfsr_state,
    output logic                lockup_err
);

    logic [WIDTH-1:0]    state_q, state_d;
    logic [OUT_BITS-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                lockup_q, lockup_d;

    logic [WIDTH-1:0]    step_state;
    logic [OUT_BITS-1:0] step_word;
    logic                advance;
    logic                drain;

    // OUT_BITS Galois steps unrolled; the earliest bit lands in the word MSB.
    always_comb begin
        step_state = state_q;
        step_word  = '0;
        for (int i = 0; i < OUT_BITS; i++) begin
            step_word[OUT_BITS-1-i] = step_state[WIDTH-1];
            step_state = {step_state[WIDTH-2:0], 1'b0}
                       ^ (step_state[WIDTH-1] ? POLY : '0);
        end
    end

    assign advance = en & (~valid_q | out_ready);
    assign drain   = ~en & valid_q & out_ready;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        valid_d  = valid_q;
        lockup_d = lockup_q;
        if (seed_load) begin
            // A zero seed would lock the LFSR; substitute the reset value.
            if (seed_in == '0) begin
                state_d  = RESET_VALUE;
                lockup_d = 1'b1;
            end else begin
                state_d  = seed_in;
            end
            valid_d = 1'b0;
        end else if (advance) begin
            state_d = step_state;
            data_d  = step_word;
            valid_d = 1'b1;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RESET_VALUE;
            data_q   <= '0;
            valid_q  <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            lockup_q <= lockup_d;
        end
    end

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign lfsr_state = state_q;
    assign lockup_err = lockup_q;

endmodule

// File: tb/tb_prbs_gen_param.sv
// Bench for prbs_gen_param: directed scenarios plus randomized traffic
// against a table-driven model of the maximal-length sequence.
module tb_prbs_gen_param;

    localparam int PERIOD = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       seed_load = 1'b0;
    logic [7:0] seed_in = 8'h00;
    logic       out_ready = 1'b0;

    logic       d1_data;
    logic       d1_valid;
    logic [7:0] d1_state;
    logic       d1_lock;
    logic [1:0] d2_data;
    logic       d2_valid;
    logic [7:0] d2_state;
    logic       d2_lock;

    int checks = 0;
    int passes = 0;

    bit         seq [PERIOD];
    logic [7:0] st  [PERIOD];

    always #5 clk = ~clk;

    prbs_gen_param dut1 (
        .clk(clk), .rst(rst), .en(en),
        .seed_load(seed_load), .seed_in(seed_in),
        .out_data(d1_data), .out_valid(d1_valid),
        .out_ready(out_ready), .lfsr_state(d1_state),
        .lockup_err(d1_lock)
    );

    prbs_gen_param #(.OUT_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .en(en),
        .seed_load(seed_load), .seed_in(seed_in),
        .out_data(d2_data), .out_valid(d2_valid),
        .out_ready(out_ready), .lfsr_state(d2_state),
        .lockup_err(d2_lock)
    );

    // Whole sequence as a table: st[k] is the register after k steps from 0xB4.
    task automatic build_table();
        int s;
        s = 'hB4;
        for (int k = 0; k < PERIOD; k++) begin
            st[k]  = s[7:0];
            seq[k] = (s >= 128);
            s = ((s * 2) % 256) ^ ((s >= 128) ? 'h1D : 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en = 0; seed_load = 0; seed_in = 0; out_ready = 0;
        rst = 1;
        #1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        en = 0; seed_load = 0; out_ready = 0;
        rst = 1;
        #1;
        checks++;
        if (d1_state !== 8'hB4 || d1_valid !== 1'b0 ||
            d1_data !== 1'b0 || d1_lock !== 1'b0)
            $display("FAIL reset: state=%h valid=%b data=%b lock=%b want b4/0/0/0",
                     d1_state, d1_valid, d1_data, d1_lock);
        else passes++;
        tick();
        rst = 0;
    endtask

    task automatic test_sequence();
        do_reset();
        en = 1; out_ready = 1;
        for (int k = 1; k <= PERIOD; k++) begin
            tick();
            checks++;
            if (d1_state !== st[k % PERIOD] || d1_data !== seq[k-1] ||
                d1_valid !== 1'b1)
                $display("FAIL seq step %0d: state=%h data=%b valid=%b want %h/%b/1",
                         k, d1_state, d1_data, d1_valid, st[k % PERIOD], seq[k-1]);
            else passes++;
            if (k == 1) begin
                checks++;
                if (d1_state !== 8'h75 || d1_data !== 1'b1)
                    $display("FAIL seq first: state=%h data=%b want 75/1",
                             d1_state, d1_data);
                else passes++;
            end
            if (k == 2) begin
                checks++;
                if (d1_state !== 8'hEA || d1_data !== 1'b0)
                    $display("FAIL seq second: state=%h data=%b want ea/0",
                             d1_state, d1_data);
                else passes++;
            end
        end
        checks++;
        if (d1_state !== 8'hB4)
            $display("FAIL seq period: state=%h want b4", d1_state);
        else passes++;
    endtask

    task automatic test_two_bits();
        do_reset();
        en = 1; out_ready = 1;
        tick();
        checks++;
        if (d2_data !== 2'b10 || d2_state !== 8'hEA || d2_valid !== 1'b1)
            $display("FAIL two_bits w0: data=%b state=%h valid=%b want 10/ea/1",
                     d2_data, d2_state, d2_valid);
        else passes++;
        tick();
        checks++;
        if (d2_data !== 2'b11 || d2_state !== 8'h8F)
            $display("FAIL two_bits w1: data=%b state=%h want 11/8f",
                     d2_data, d2_state);
        else passes++;
    endtask

    task automatic test_backpressure();
        int idx;
        do_reset();
        en = 1; out_ready = 0;
        tick();
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (d1_valid !== 1'b1 || d1_data !== seq[0] || d1_state !== st[1])
                $display("FAIL stall %0d: valid=%b data=%b state=%h want 1/%b/%h",
                         c, d1_valid, d1_data, d1_state, seq[0], st[1]);
            else passes++;
        end
        out_ready = 1;
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (d1_valid !== 1'b1 || d1_data !== seq[idx])
                $display("FAIL released bit %0d: valid=%b data=%b want 1/%b",
                         idx, d1_valid, d1_data, seq[idx]);
            else passes++;
            idx++;
            tick();
        end
    endtask

    task automatic test_seed_flush();
        do_reset();
        en = 1; out_ready = 0;
        tick();
        tick();
        seed_load = 1; seed_in = 8'h01;
        tick();
        seed_load = 0;
        checks++;
        if (d1_valid !== 1'b0 || d1_state !== 8'h01)
            $display("FAIL seed flush: valid=%b state=%h want 0/01",
                     d1_valid, d1_state);
        else passes++;
        tick();
        checks++;
        if (d1_valid !== 1'b1 || d1_data !== 1'b0 || d1_state !== 8'h02)
            $display("FAIL seed word: valid=%b data=%b state=%h want 1/0/02",
                     d1_valid, d1_data, d1_state);
        else passes++;
    endtask

    task automatic test_lockup();
        do_reset();
        checks++;
        if (d1_lock !== 1'b0)
            $display("FAIL lockup pre: lock=%b want 0", d1_lock);
        else passes++;
        en = 1; out_ready = 1;
        tick();
        tick();
        seed_load = 1; seed_in = 8'h00;
        tick();
        seed_load = 0;
        checks++;
        if (d1_state !== 8'hB4 || d1_lock !== 1'b1 || d1_valid !== 1'b0)
            $display("FAIL lockup seed: state=%h lock=%b valid=%b want b4/1/0",
                     d1_state, d1_lock, d1_valid);
        else passes++;
        for (int c = 0; c < 10; c++) begin
            out_ready = c[0];
            tick();
        end
        checks++;
        if (d1_lock !== 1'b1)
            $display("FAIL lockup sticky: lock=%b want 1", d1_lock);
        else passes++;
        rst = 1;
        #1;
        checks++;
        if (d1_lock !== 1'b0)
            $display("FAIL lockup clear: lock=%b want 0", d1_lock);
        else passes++;
        tick();
        rst = 0;
    endtask

    task automatic test_async_reset();
        do_reset();
        en = 1; out_ready = 1;
        for (int c = 0; c < 7; c++) tick();
        rst = 1;
        #2;
        checks++;
        if (d1_state !== 8'hB4 || d1_valid !== 1'b0 || d1_data !== 1'b0)
            $display("FAIL async reset: state=%h valid=%b data=%b want b4/0/0",
                     d1_state, d1_valid, d1_data);
        else passes++;
        tick();
        rst = 0;
        tick();
        checks++;
        if (d1_state !== 8'h75 || d1_data !== 1'b1 || d1_valid !== 1'b1)
            $display("FAIL restart: state=%h data=%b valid=%b want 75/1/1",
                     d1_state, d1_data, d1_valid);
        else passes++;
    endtask

    task automatic test_random();
        int  p1, p2, k;
        bit  v1, v2, lk;
        bit  b1;
        bit [1:0] b2;
        do_reset();
        p1 = 0; p2 = 0; v1 = 0; v2 = 0; lk = 0; b1 = 0; b2 = 0;
        for (int c = 0; c < 600; c++) begin
            en        = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            seed_load = ($urandom_range(0, 24) == 0);
            k = 0;
            seed_in = 8'h00;
            if (seed_load && $urandom_range(0, 3) != 0) begin
                k = $urandom_range(0, PERIOD - 1);
                seed_in = st[k];
            end
            if (seed_load) begin
                if (seed_in == 8'h00) lk = 1;
                p1 = k; p2 = k; v1 = 0; v2 = 0;
            end else begin
                if (en && (!v1 || out_ready)) begin
                    b1 = seq[p1]; p1 = (p1 + 1) % PERIOD; v1 = 1;
                end else if (!en && v1 && out_ready) v1 = 0;
                if (en && (!v2 || out_ready)) begin
                    b2 = {seq[p2], seq[(p2 + 1) % PERIOD]};
                    p2 = (p2 + 2) % PERIOD; v2 = 1;
                end else if (!en && v2 && out_ready) v2 = 0;
            end
            tick();
            checks++;
            if (d1_state !== st[p1] || d1_valid !== v1 ||
                (v1 && d1_data !== b1) || d1_lock !== lk)
                $display("FAIL rand1 cyc %0d: state=%h valid=%b data=%b lock=%b want %h/%b/%b/%b",
                         c, d1_state, d1_valid, d1_data, d1_lock, st[p1], v1, b1, lk);
            else passes++;
            checks++;
            if (d2_state !== st[p2] || d2_valid !== v2 ||
                (v2 && d2_data !== b2) || d2_lock !== lk)
                $display("FAIL rand2 cyc %0d: state=%h valid=%b data=%b lock=%b want %h/%b/%b/%b",
                         c, d2_state, d2_valid, d2_data, d2_lock, st[p2], v2, b2, lk);
            else passes++;
        end
        seed_load = 0;
    endtask

    initial begin
        build_table();
        test_reset();
        test_sequence();
        test_two_bits();
        test_backpressure();
        test_seed_flush();
        test_lockup();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
